seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle iterative restoring divider. Performs signed or unsigned 32-bit division, one quotient bit per cycle.
- Sits beside the combinational ALU in the execute stage of the multi-cycle CPU.
- The CPU control FSM is the initiator. It hands operands over a valid/ready request channel and collects quotient/remainder over a valid/ready response channel.

Parameters:
DATA_WIDTH, 32, operand/result width (same as the datapath width)
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  divider can accept a request
dividend  input  DATA_WIDTH  dividend, sampled on accept
divisor  input  DATA_WIDTH  divisor, sampled on accept
is_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled on accept
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
quotient  output  DATA_WIDTH  quotient
remainder  output  DATA_WIDTH  remainder
div_by_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient, remainder, div_by_zero all 0.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, PREP, ITER, FIXUP, DONE.
  - in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: accept when in_valid && in_ready, then go to PREP. Latch:
  - is_signed;
  - sign_q = signed && (dividend[MSB] ^ divisor[MSB]);
  - sign_r = signed && dividend[MSB];
  - the magnitudes |dividend| and |divisor| (negate if signed and MSB set; unsigned uses raw values).
- PREP:
  - If divisor == 0: go to DONE with quotient = all ones, remainder = original dividend, div_by_zero = 1.
  - Otherwise: clear the partial remainder (DATA_WIDTH+1 bits), load the quotient shift register with |dividend|, set cnt=0, go to ITER.
- ITER, one step per cycle:
  - Shift {rem, q} left by 1.
  - trial = rem_shifted - {0,|divisor|}.
  - If trial is non-negative: rem = trial, q[0] = 1. Otherwise rem is unchanged and q[0] = 0.
  - cnt increments. When cnt == DATA_WIDTH-1, go to FIXUP.
- FIXUP:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -rem : rem.
  - div_by_zero = 0. Go to DONE.
- DONE: hold all outputs stable while out_valid && !out_ready. When out_ready=1, go to IDLE at that edge.
  - in_ready stays 0 until the cycle after the handoff, so there is no back-to-back overlap.
- Latency:
  - Accept edge E0. out_valid is first high after edge E0+DATA_WIDTH+2 (34 cycles for 32).
  - Divide-by-zero: out_valid high after E0+2.
- Arithmetic rules:
  - Signed overflow case (-2^(W-1) / -1): quotient = 0x80000000, remainder = 0. This falls out naturally from magnitude arithmetic modulo 2^W.
  - Remainder always takes the sign of the dividend; quotient truncates toward zero.
- Boundary conditions:
  - in_valid while busy is ignored; the requester must hold its request.
  - Operand inputs changing after accept have no effect.
  - out_ready asserted outside DONE is ignored.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in PREP, if |divisor| > |dividend| (and divisor != 0), go straight to DONE.
  - quotient = 0, remainder = original dividend, div_by_zero = 0.
  - Latency 2 cycles from accept.
- Undefined: every nonzero-divisor request takes the full DATA_WIDTH+2 cycles. Results are bit-identical in both builds.

Test Plan:
- Reset held 3 cycles, then released -> in_ready=1, out_valid=0, quotient=remainder=0, div_by_zero=0.
- Unsigned 100/7 -> quotient=14, remainder=2, out_valid exactly 34 cycles after accept.
- Signed -7/2 (0xFFFFFFF9, 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
- Divide by zero, dividend 0x12345678 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, out_valid 2 cycles after accept.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout, new in_valid ignored. Then out_ready=1 for one cycle -> IDLE, and the next request is accepted. Also assert rst mid-ITER -> IDLE next cycle, no out_valid pulse.

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/response handshake bundle between the CPU control FSM and seq_divider.
interface seq_divider_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  is_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  // Initiator side (CPU control FSM)
  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned.
// Optional build macro DIV_EARLY_OUT_EN: skip the iterations when
// |divisor| > |dividend| (results are identical, only latency changes).
module seq_divider #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned MSB = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e               state_q,      state_d;
  logic                 in_ready_q,   in_ready_d;
  logic                 out_valid_q,  out_valid_d;
  logic [W-1:0]         quotient_q,   quotient_d;
  logic [W-1:0]         remainder_q,  remainder_d;
  logic                 dbz_q,        dbz_d;
  logic                 neg_quo_q,    neg_quo_d;
  logic                 neg_rem_q,    neg_rem_d;
  logic [W-1:0]         dvd_mag_q,    dvd_mag_d;
  logic [W-1:0]         dvs_mag_q,    dvs_mag_d;
  logic [W-1:0]         quo_sr_q,     quo_sr_d;
  logic [W-1:0]         rem_q,        rem_d;
  logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;
  logic                 bypass_q,     bypass_d;
  logic                 dbz_pend_q,   dbz_pend_d;

  // Between steps the partial remainder is always below |divisor|, so it fits
  // in W bits; the extra top bit only exists in the shifted/trial values.
  logic [W:0]   rem_sh;
  logic [W:0]   trial;
  logic [W-1:0] orig_dvd;

  // One restoring step and the original dividend rebuilt from its magnitude
  assign rem_sh   = {rem_q, quo_sr_q[MSB]};
  assign trial    = rem_sh - {1'b0, dvs_mag_q};
  assign orig_dvd = neg_rem_q ? W'(-dvd_mag_q) : dvd_mag_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dvd_mag_d   = dvd_mag_q;
    dvs_mag_d   = dvs_mag_q;
    quo_sr_d    = quo_sr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    bypass_d    = bypass_q;
    dbz_pend_d  = dbz_pend_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          neg_quo_d  = bus.is_signed && (bus.dividend[MSB] ^ bus.divisor[MSB]);
          neg_rem_d  = bus.is_signed && bus.dividend[MSB];
          dvd_mag_d  = (bus.is_signed && bus.dividend[MSB]) ? W'(-bus.dividend) : bus.dividend;
          dvs_mag_d  = (bus.is_signed && bus.divisor[MSB])  ? W'(-bus.divisor)  : bus.divisor;
          in_ready_d = 1'b0;
          state_d    = PREP;
        end
      end

      // Special results skip ITER and reuse FIXUP as the single result-load point
      PREP: begin
        bypass_d   = 1'b0;
        dbz_pend_d = 1'b0;
        cnt_d      = '0;
        if (dvs_mag_q == '0) begin
          bypass_d   = 1'b1;
          dbz_pend_d = 1'b1;
          quo_sr_d   = '1;
          rem_d      = orig_dvd;
          state_d    = FIXUP;
`ifdef DIV_EARLY_OUT_EN
        end else if (dvs_mag_q > dvd_mag_q) begin
          bypass_d = 1'b1;
          quo_sr_d = '0;
          rem_d    = orig_dvd;
          state_d  = FIXUP;
`endif
        end else begin
          rem_d    = '0;
          quo_sr_d = dvd_mag_q;
          state_d  = ITER;
        end
      end

      ITER: begin
        if (!trial[W]) begin
          rem_d    = trial[W-1:0];
          quo_sr_d = {quo_sr_q[MSB-1:0], 1'b1};
        end else begin
          rem_d    = rem_sh[W-1:0];
          quo_sr_d = {quo_sr_q[MSB-1:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        if (bypass_q) begin
          quotient_d  = quo_sr_q;
          remainder_d = rem_q;
        end else begin
          quotient_d  = neg_quo_q ? W'(-quo_sr_q) : quo_sr_q;
          remainder_d = neg_rem_q ? W'(-rem_q)    : rem_q;
        end
        dbz_d       = dbz_pend_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvd_mag_q   <= '0;
      dvs_mag_q   <= '0;
      quo_sr_q    <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      bypass_q    <= 1'b0;
      dbz_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dvd_mag_q   <= dvd_mag_d;
      dvs_mag_q   <= dvs_mag_d;
      quo_sr_q    <= quo_sr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      bypass_q    <= bypass_d;
      dbz_pend_q  <= dbz_pend_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: fixed vectors, random ops against an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_seq_divider;

  localparam int unsigned W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 2;
`else
  localparam int SMALL_LAT = 34;
`endif

  logic clk;
  logic rst;

  seq_divider_if #(.DATA_WIDTH(W)) bus ();

  seq_divider #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         sgn;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic (truncating /, dividend-signed %)
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output int lat);
    longint sa, sb, qq, rr, ma, mb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (sb == 0) begin
      q = '1; r = a; z = 1'b1; lat = 2;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
      z  = 1'b0;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      lat = (mb > ma) ? SMALL_LAT : 34;
    end
  endfunction

  // Full transaction: wait ready, present, scramble after accept, measure latency, hand off
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    bus.is_signed = ~s;
    lat = 0;
    ok  = 1'b0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q, r, a, b, eq, er, q0, r0;
    logic         z, s, ez;
    int           lat, elat, n;
    bit           ok, stable, seen;

    vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 34};
    vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34};
    vecs[2] = '{32'hFFFFFFF9,  32'd2,         1'b0, 32'h7FFFFFFC,  32'd1,         1'b0, 34};
    vecs[3] = '{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678,  1'b1, 2};
    vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0, 34};
    vecs[5] = '{32'd5,         32'd10,        1'b0, 32'd0,         32'd5,         1'b0, SMALL_LAT};
    vecs[6] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0, 34};
    vecs[7] = '{32'hFFFFFFF8,  32'hFFFFFFFD,  1'b1, 32'd2,         32'hFFFFFFFE,  1'b0, 34};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  W'(bus.in_ready), 32'd1);
    chk("rst_out_valid", W'(bus.out_valid), 32'd0);
    chk("rst_quotient",  bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    chk("rst_dbz",       W'(bus.div_by_zero), 32'd0);

    // Fixed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, q, r, z, lat, ok);
      chk($sformatf("vec%0d_done", i), W'(ok), 32'd1);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_z", i), W'(z), W'(vecs[i].z));
      chk($sformatf("vec%0d_lat", i), W'(lat), W'(vecs[i].lat));
    end

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'(-$urandom_range(1, 15));
        3:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, s, eq, er, ez, elat);
      run_op(a, b, s, q, r, z, lat, ok);
      chk($sformatf("rnd%0d_done", i), W'(ok), 32'd1);
      chk($sformatf("rnd%0d_q %h/%h s%0d", i, a, b, s), q, eq);
      chk($sformatf("rnd%0d_r %h/%h s%0d", i, a, b, s), r, er);
      chk($sformatf("rnd%0d_z", i), W'(z), W'(ez));
      chk($sformatf("rnd%0d_lat", i), W'(lat), W'(elat));
    end

    // Backpressure: hold result in DONE, ignore new requests
    @(negedge clk);
    bus.dividend = 32'd100; bus.divisor = 32'd7; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", W'(bus.out_valid), 32'd1);
    q0 = bus.quotient;
    r0 = bus.remainder;
    chk("bp_q", q0, 32'd14);
    chk("bp_r", r0, 32'd2);
    bus.in_valid = 1'b1; bus.dividend = 32'hDEAD; bus.divisor = 32'd3;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.quotient !== q0 || bus.remainder !== r0 || !bus.out_valid || bus.in_ready)
        stable = 1'b0;
    end
    chk("bp_stable", W'(stable), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_in_ready",  W'(bus.in_ready), 32'd1);
    chk("bp_idle_out_valid", W'(bus.out_valid), 32'd0);
    run_op(32'd50, 32'd5, 1'b0, q, r, z, lat, ok);
    chk("bp_next_done", W'(ok), 32'd1);
    chk("bp_next_q",    q, 32'd10);
    chk("bp_next_r",    r, 32'd0);
    chk("bp_next_lat",  W'(lat), 32'd34);

    // Reset in the middle of the iterations
    @(negedge clk);
    bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready",  W'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", W'(bus.out_valid), 32'd0);
    chk("midrst_quotient",  bus.quotient, 32'd0);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", W'(seen), 32'd0);
    bus.out_ready = 1'b0;

    run_op(32'hFFFFFF9C, 32'd10, 1'b1, q, r, z, lat, ok);
    chk("post_rst_q", q, 32'hFFFFFFF6);
    chk("post_rst_r", r, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
